xbox_mem_bank: RTL and testbench

XBOX_MEM_BANK -- requirements
Module: xbox_mem_bank

---
 rtl/xbox_pkg.sv | 25 ++
 rtl/xbox_be_merge.sv | 22 ++
 rtl/xbox_mem_bank.sv | 157 +++++++++++++++
 tb/tb_xbox_mem_bank.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/xbox_pkg.sv
// xbox_pkg: shared geometry of the accelerator/host memory bank.
//   LINE_W       line width in bits (256)
//   LINE_BYTES   bytes per line (32), LINE_WORDS words per line (8)
//   WORD_SEL_W   width of the word-select field of a host address (3)
//   byte_parity  per-byte even-parity vector of a full line
package xbox_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned LINE_W     = 256;
  localparam int unsigned LINE_BYTES = LINE_W / BYTE_W;
  localparam int unsigned LINE_WORDS = LINE_W / WORD_W;
  localparam int unsigned WORD_BYTES = WORD_W / BYTE_W;
  localparam int unsigned WORD_SEL_W = 3;

  function automatic logic [LINE_BYTES-1:0] byte_parity(input logic [LINE_W-1:0] line);
    logic [LINE_BYTES-1:0] p;
    p = '0;
    for (int unsigned k = 0; k < LINE_BYTES; k++) begin
      p[k] = ^line[k*BYTE_W +: BYTE_W];
    end
    return p;
  endfunction

endpackage

// File: rtl/xbox_be_merge.sv
// xbox_be_merge: byte-enable merge of a new line over an old line.
//   old_line  current line contents
//   new_line  incoming write data
//   mask      one bit per byte; 1 takes the byte from new_line
//   merged    resulting line
module xbox_be_merge
  import xbox_pkg::*;
(
  input  logic [LINE_W-1:0]     old_line,
  input  logic [LINE_W-1:0]     new_line,
  input  logic [LINE_BYTES-1:0] mask,
  output logic [LINE_W-1:0]     merged
);

  always_comb begin
    merged = old_line;
    for (int unsigned k = 0; k < LINE_BYTES; k++) begin
      if (mask[k]) merged[k*BYTE_W +: BYTE_W] = new_line[k*BYTE_W +: BYTE_W];
    end
  end

endmodule

// File: rtl/xbox_mem_bank.sv
// xbox_mem_bank: 2^LOG2_LINES x 256-bit line memory shared by an accelerator
// (full-line port, absolute priority) and a host (32-bit word port).
//   clk, rst_n                 clock, asynchronous active-low reset
//   xlr_mem_addr/wdata/be      accelerator line address, write line, byte enables
//   xlr_mem_rd/wr              accelerator read/write strobes
//   xlr_mem_rdata              registered accelerator read line
//   host_req/wr/addr/wdata/be  host word request ({line, word})
//   host_gnt                   request accepted this cycle (combinational)
//   host_rvalid/rdata          host read response, one cycle after grant
//   coll_cnt                   saturating count of denied host request cycles
//   par_err/par_clr            sticky parity error and its clear
// Optional feature: define XBOX_MEM_PARITY_EN for per-byte even parity.
module xbox_mem_bank
  import xbox_pkg::*;
#(
  parameter int unsigned LOG2_LINES = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [LOG2_LINES-1:0]            xlr_mem_addr,
  input  logic [255:0]                     xlr_mem_wdata,
  input  logic [31:0]                      xlr_mem_be,
  input  logic                             xlr_mem_rd,
  input  logic                             xlr_mem_wr,
  output logic [255:0]                     xlr_mem_rdata,
  input  logic                             host_req,
  input  logic                             host_wr,
  input  logic [LOG2_LINES+WORD_SEL_W-1:0] host_addr,
  input  logic [31:0]                      host_wdata,
  input  logic [3:0]                       host_be,
  output logic                             host_gnt,
  output logic                             host_rvalid,
  output logic [31:0]                      host_rdata,
  output logic [15:0]                      coll_cnt,
  output logic                             par_err,
  input  logic                             par_clr
);

  localparam int unsigned LINES = 1 << LOG2_LINES;

  logic [LINE_W-1:0]     mem [LINES];

  logic [LOG2_LINES-1:0] host_line;
  logic [WORD_SEL_W-1:0] host_word;
  logic [LINE_W-1:0]     host_line_data;
  logic [WORD_W-1:0]     host_word_data;

  logic                  wr_en;
  logic [LOG2_LINES-1:0] wr_line;
  logic [LINE_W-1:0]     wr_new;
  logic [LINE_BYTES-1:0] wr_mask;
  logic [LINE_W-1:0]     wr_merged;

  assign host_line = host_addr[LOG2_LINES+WORD_SEL_W-1:WORD_SEL_W];
  assign host_word = host_addr[WORD_SEL_W-1:0];
  assign host_gnt  = host_req & ~(xlr_mem_rd | xlr_mem_wr);

  assign host_line_data = mem[host_line];
  assign host_word_data = host_line_data[{host_word, 5'd0} +: WORD_W];

  // Accelerator and host writes never coincide (host is denied whenever the
  // accelerator is active), so one merge instance serves both ports.
  always_comb begin
    wr_en   = xlr_mem_wr | (host_gnt & host_wr);
    wr_line = host_line;
    wr_new  = {LINE_WORDS{host_wdata}};
    wr_mask = '0;
    wr_mask[WORD_BYTES-1:0] = host_be;
    wr_mask = wr_mask << {host_word, 2'b00};
    if (xlr_mem_wr) begin
      wr_line = xlr_mem_addr;
      wr_new  = xlr_mem_wdata;
      wr_mask = xlr_mem_be;
    end
  end

  xbox_be_merge u_merge (
    .old_line (mem[wr_line]),
    .new_line (wr_new),
    .mask     (wr_mask),
    .merged   (wr_merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LINES; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_line] <= wr_merged;
    end
  end

  // Read samples the pre-write line, giving read-before-write on collisions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xlr_mem_rdata <= '0;
    end else if (xlr_mem_rd) begin
      xlr_mem_rdata <= mem[xlr_mem_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      host_rvalid <= host_gnt & ~host_wr;
      if (host_gnt && !host_wr) host_rdata <= host_word_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coll_cnt <= '0;
    end else if (host_req && !host_gnt && coll_cnt != 16'hFFFF) begin
      coll_cnt <= coll_cnt + 16'd1;
    end
  end

`ifdef XBOX_MEM_PARITY_EN
  logic [LINE_BYTES-1:0] par_mem [LINES];
  logic [LINE_BYTES-1:0] xlr_diff;
  logic [LINE_BYTES-1:0] host_diff;
  logic                  par_bad;

  // Only written bytes get fresh parity, so an existing corruption in an
  // untouched byte of the same line stays detectable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LINES; i++) par_mem[i] <= '0;
    end else if (wr_en) begin
      par_mem[wr_line] <= (par_mem[wr_line] & ~wr_mask) | (byte_parity(wr_merged) & wr_mask);
    end
  end

  always_comb begin
    xlr_diff  = byte_parity(mem[xlr_mem_addr]) ^ par_mem[xlr_mem_addr];
    host_diff = byte_parity(host_line_data) ^ par_mem[host_line];
    par_bad   = (xlr_mem_rd & (|xlr_diff)) |
                (host_gnt & ~host_wr & (|host_diff[{host_word, 2'b00} +: WORD_BYTES]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err <= 1'b0;
    end else if (par_bad) begin
      par_err <= 1'b1;
    end else if (par_clr) begin
      par_err <= 1'b0;
    end
  end
`else
  logic unused_par_clr;
  assign unused_par_clr = par_clr;
  assign par_err        = 1'b0;
`endif

endmodule

// File: tb/tb_xbox_mem_bank.sv
// tb_xbox_mem_bank: directed self-checking bench for xbox_mem_bank.
module tb_xbox_mem_bank;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   xlr_mem_addr;
  logic [255:0] xlr_mem_wdata;
  logic [31:0]  xlr_mem_be;
  logic         xlr_mem_rd;
  logic         xlr_mem_wr;
  logic [255:0] xlr_mem_rdata;
  logic         host_req;
  logic         host_wr;
  logic [6:0]   host_addr;
  logic [31:0]  host_wdata;
  logic [3:0]   host_be;
  logic         host_gnt;
  logic         host_rvalid;
  logic [31:0]  host_rdata;
  logic [15:0]  coll_cnt;
  logic         par_err;
  logic         par_clr;

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [255:0] exp_line;

  always #5 clk = ~clk;

  xbox_mem_bank #(.LOG2_LINES(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .xlr_mem_addr  (xlr_mem_addr),
    .xlr_mem_wdata (xlr_mem_wdata),
    .xlr_mem_be    (xlr_mem_be),
    .xlr_mem_rd    (xlr_mem_rd),
    .xlr_mem_wr    (xlr_mem_wr),
    .xlr_mem_rdata (xlr_mem_rdata),
    .host_req      (host_req),
    .host_wr       (host_wr),
    .host_addr     (host_addr),
    .host_wdata    (host_wdata),
    .host_be       (host_be),
    .host_gnt      (host_gnt),
    .host_rvalid   (host_rvalid),
    .host_rdata    (host_rdata),
    .coll_cnt      (coll_cnt),
    .par_err       (par_err),
    .par_clr       (par_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    xlr_mem_addr  = '0;
    xlr_mem_wdata = '0;
    xlr_mem_be    = '0;
    xlr_mem_rd    = 1'b0;
    xlr_mem_wr    = 1'b0;
    host_req      = 1'b0;
    host_wr       = 1'b0;
    host_addr     = '0;
    host_wdata    = '0;
    host_be       = '0;
    par_clr       = 1'b0;
    #12;
    chk("rst_xlr_rdata", xlr_mem_rdata, '0);
    chk("rst_rvalid", 256'(host_rvalid), 256'd0);
    chk("rst_rdata", 256'(host_rdata), 256'd0);
    chk("rst_coll_cnt", 256'(coll_cnt), 256'd0);
    chk("rst_par_err", 256'(par_err), 256'd0);
    rst_n = 1'b1;
    tick();

    // Full-line accelerator write, words 1..8, then read back
    xlr_mem_addr = 4'd1; xlr_mem_wr = 1'b1; xlr_mem_be = 32'hFFFF_FFFF;
    xlr_mem_wdata = {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    tick();
    xlr_mem_wr = 1'b0; xlr_mem_rd = 1'b1;
    tick();
    xlr_mem_rd = 1'b0;
    chk("xlr_full_line", xlr_mem_rdata,
        {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1});
    xlr_mem_addr = 4'd0;
    tick();
    chk("xlr_rdata_hold", xlr_mem_rdata,
        {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1});

    // Partial byte-enable write over an all-AA line
    xlr_mem_addr = 4'd2; xlr_mem_wr = 1'b1; xlr_mem_be = 32'hFFFF_FFFF;
    xlr_mem_wdata = {32{8'hAA}};
    tick();
    xlr_mem_be = 32'h0000_000F; xlr_mem_wdata = {8{32'h1234_5678}};
    tick();
    xlr_mem_wr = 1'b0; xlr_mem_rd = 1'b1;
    tick();
    xlr_mem_rd = 1'b0;
    chk("xlr_partial_be", xlr_mem_rdata, {{7{32'hAAAA_AAAA}}, 32'h1234_5678});

    // Host read of line 1 word 2 blocked by accelerator reads for 3 cycles
    host_req = 1'b1; host_wr = 1'b0; host_addr = {4'd1, 3'd2};
    xlr_mem_rd = 1'b1; xlr_mem_addr = 4'd0;
    #1;
    chk("gnt_denied", 256'(host_gnt), 256'd0);
    tick(); tick(); tick();
    chk("coll_cnt_3", 256'(coll_cnt), 256'd3);
    chk("xlr_rd_line0_zero", xlr_mem_rdata, '0);
    xlr_mem_rd = 1'b0;
    #1;
    chk("gnt_cycle4", 256'(host_gnt), 256'd1);
    tick();
    host_req = 1'b0;
    chk("host_rvalid_rd", 256'(host_rvalid), 256'd1);
    chk("host_rdata_rd", 256'(host_rdata), 256'd3);
    tick();
    chk("host_rvalid_pulse", 256'(host_rvalid), 256'd0);
    chk("host_rdata_hold", 256'(host_rdata), 256'd3);
    chk("coll_cnt_stable", 256'(coll_cnt), 256'd3);

    // Host write line 0 word 5 low half, then back-to-back read
    host_req = 1'b1; host_wr = 1'b1; host_addr = {4'd0, 3'd5};
    host_wdata = 32'hDEAD_BEEF; host_be = 4'b0011;
    #1;
    chk("gnt_host_wr", 256'(host_gnt), 256'd1);
    tick();
    chk("no_rvalid_on_wr", 256'(host_rvalid), 256'd0);
    host_wr = 1'b0;
    tick();
    host_req = 1'b0;
    chk("host_rvalid_wr_rd", 256'(host_rvalid), 256'd1);
    chk("host_rdata_beef", 256'(host_rdata), 256'h0000_BEEF);
    xlr_mem_addr = 4'd0; xlr_mem_rd = 1'b1;
    tick();
    xlr_mem_rd = 1'b0;
    exp_line = '0;
    exp_line[191:160] = 32'h0000_BEEF;
    chk("host_wr_placement", xlr_mem_rdata, exp_line);

    // Simultaneous accelerator read and write to line 3
    xlr_mem_addr = 4'd3; xlr_mem_wr = 1'b1; xlr_mem_be = 32'hFFFF_FFFF;
    xlr_mem_wdata = {8{32'h1111_1111}};
    tick();
    xlr_mem_rd = 1'b1; xlr_mem_wdata = {8{32'h2222_2222}};
    tick();
    xlr_mem_wr = 1'b0;
    chk("rd_before_wr", xlr_mem_rdata, {8{32'h1111_1111}});
    tick();
    xlr_mem_rd = 1'b0;
    chk("rd_after_wr", xlr_mem_rdata, {8{32'h2222_2222}});

`ifdef XBOX_MEM_PARITY_EN
    force dut.mem[4] = 256'h1;
    xlr_mem_addr = 4'd4; xlr_mem_rd = 1'b1;
    tick();
    xlr_mem_rd = 1'b0;
    release dut.mem[4];
    chk("par_err_set", 256'(par_err), 256'd1);
    tick();
    chk("par_err_sticky", 256'(par_err), 256'd1);
    par_clr = 1'b1;
    tick();
    par_clr = 1'b0;
    chk("par_err_cleared", 256'(par_err), 256'd0);
`else
    par_clr = 1'b1;
    xlr_mem_addr = 4'd1; xlr_mem_rd = 1'b1;
    tick();
    par_clr = 1'b0; xlr_mem_rd = 1'b0;
    chk("par_err_tied0", 256'(par_err), 256'd0);
`endif

    // Reset with a granted host read in flight
    host_req = 1'b1; host_wr = 1'b0; host_addr = {4'd1, 3'd0};
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_async_coll", 256'(coll_cnt), 256'd0);
    chk("rst_async_xlr", xlr_mem_rdata, '0);
    host_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_drop_rvalid", 256'(host_rvalid), 256'd0);
    xlr_mem_addr = 4'd1; xlr_mem_rd = 1'b1;
    tick();
    xlr_mem_rd = 1'b0;
    chk("rst_mem_cleared", xlr_mem_rdata, '0);

    // Collision counter saturation
    host_req = 1'b1; host_wr = 1'b0; xlr_mem_rd = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    chk("coll_cnt_65534", 256'(coll_cnt), 256'd65534);
    tick(); tick(); tick();
    chk("coll_cnt_sat", 256'(coll_cnt), 256'hFFFF);
    host_req = 1'b0; xlr_mem_rd = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
